// File: rtl/data_io_pkg.sv
// Constants and state encoding shared by the file-download SPI transmitter and receiver.
package data_io_pkg;

  localparam logic [7:0] UIO_FILE_TX     = 8'h53;
  localparam logic [7:0] UIO_FILE_TX_DAT = 8'h54;
  localparam logic [7:0] UIO_ARG_BEGIN   = 8'h01;
  localparam logic [7:0] UIO_ARG_END     = 8'h00;

  typedef enum logic [2:0] {IDLE, FA, GAP, FD, FE, FIN} state_t;

  // Frame that follows the gap after frame `cur`; an empty download skips FD.
  function automatic state_t next_frame(input state_t cur, input logic has_data);
    case (cur)
      FA:      return has_data ? FD : FE;
      FD:      return FE;
      default: return FIN;
    endcase
  endfunction

endpackage

// File: rtl/data_io_tx_if.sv
// Control, RAM read port and SPI pins of data_io_tx; master is the transmitter's own view.
interface data_io_tx_if #(parameter int ADDR_W = 16);

  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [15:0]       len;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic              sck;
  logic              ss;
  logic              sdo;

  modport master (input start, start_addr, len, rd_data,
                  output busy, done, rd_addr, sck, ss, sdo);
  modport slave  (output start, start_addr, len, rd_data,
                  input busy, done, rd_addr, sck, ss, sdo);

endinterface

// File: rtl/data_io_tx_spi_byte_tx.sv
// SPI mode-0 byte serializer: a load presents bit 7 on sdo the next cycle, one bit per 2*CLK_DIV cycles.
// No backpressure; a load coinciding with the last falling edge chains the next byte with no sck gap.
module spi_byte_tx #(
  parameter int CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_load,
  input  logic [7:0] i_byte,
  output logic       o_sck,
  output logic       o_sdo,
  output logic       o_need_byte
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_PRE  = DIV_W'((CLK_DIV > 1) ? CLK_DIV - 2 : 0);

  logic             r_act;
  logic             r_sck;
  logic             r_sdo;
  logic [7:0]       r_sh;
  logic [2:0]       r_bit;
  logic [DIV_W-1:0] r_div;
  logic             w_half_end;

  assign w_half_end = (r_div == DIV_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_act <= 1'b0;
      r_sck <= 1'b0;
      r_sdo <= 1'b0;
      r_sh  <= 8'h00;
      r_bit <= 3'd0;
      r_div <= '0;
    end else if (i_load) begin
      r_act <= 1'b1;
      r_sck <= 1'b0;
      r_sdo <= i_byte[7];
      r_sh  <= i_byte;
      r_bit <= 3'd7;
      r_div <= '0;
    end else if (r_act) begin
      if (w_half_end) begin
        r_div <= '0;
        if (!r_sck) begin
          r_sck <= 1'b1;
        end else begin
          r_sck <= 1'b0;
          if (r_bit == 3'd0) begin
            r_act <= 1'b0;
            r_sdo <= 1'b0;
          end else begin
            r_bit <= r_bit - 3'd1;
            r_sh  <= {r_sh[6:0], 1'b0};
            r_sdo <= r_sh[6];
          end
        end
      end else begin
        r_div <= r_div + DIV_W'(1);
      end
    end
  end

  // High one cycle ahead of the last falling edge, so a registered reply lands on that edge.
  assign o_need_byte = r_act && (r_bit == 3'd0) &&
                       ((CLK_DIV == 1) ? !r_sck : (r_sck && (r_div == DIV_PRE)));
  assign o_sck = r_sck;
  assign o_sdo = r_sdo;

endmodule

// File: rtl/data_io_tx.sv
// File-download SPI master: start sends frames 53 01 | 54 + len RAM bytes | 53 00; ss falls 1 cycle after start.
// No backpressure from the receiver; start is ignored while busy.
module data_io_tx
  import data_io_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int ADDR_W  = 16,
  parameter int SS_GAP  = 4
) (
  input logic          clk,
  input logic          reset_n,
  data_io_tx_if.master bus
);

  localparam int CNT_MAX = (CLK_DIV > SS_GAP) ? CLK_DIV : SS_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] TAIL_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(SS_GAP - 1);

  state_t            r_state, r_ret, w_state_nxt;
  logic [ADDR_W-1:0] r_addr, r_rd_addr;
  logic [15:0]       r_len, r_left;
  logic [7:0]        r_hold, w_byte;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_tail, r_load_pend, r_iss, r_cap;
  logic              w_load, w_need, w_in_frame, w_enter, w_tail_end;
  logic              w_sck, w_sdo;

  spi_byte_tx #(.CLK_DIV(CLK_DIV)) u_byte_tx (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_load      (w_load),
    .i_byte      (w_byte),
    .o_sck       (w_sck),
    .o_sdo       (w_sdo),
    .o_need_byte (w_need)
  );

  assign w_in_frame = (r_state == FA) || (r_state == FD) || (r_state == FE);
  assign w_tail_end = r_tail && (r_cnt == TAIL_LAST);
  assign w_enter    = w_load && !w_in_frame;

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_byte      = 8'h00;
    unique case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_state_nxt = FA;
          w_load      = 1'b1;
          w_byte      = UIO_FILE_TX;
        end
      end
      FA, FD, FE: begin
        if (r_load_pend && (r_left != 16'd0)) begin
          w_load = 1'b1;
          w_byte = (r_state == FD) ? r_hold :
                   ((r_state == FA) ? UIO_ARG_BEGIN : UIO_ARG_END);
        end
        if (w_tail_end) w_state_nxt = GAP;
      end
      GAP: begin
        if (r_cnt == GAP_LAST) begin
          w_state_nxt = r_ret;
          if (r_ret != FIN) begin
            w_load = 1'b1;
            w_byte = (r_ret == FD) ? UIO_FILE_TX_DAT : UIO_FILE_TX;
          end
        end
      end
      FIN:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_ret       <= FA;
      r_addr      <= '0;
      r_rd_addr   <= '0;
      r_len       <= 16'd0;
      r_left      <= 16'd0;
      r_hold      <= 8'h00;
      r_cnt       <= '0;
      r_tail      <= 1'b0;
      r_load_pend <= 1'b0;
      r_iss       <= 1'b0;
      r_cap       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_load_pend <= w_need;
      r_iss       <= 1'b0;
      r_cap       <= r_iss;
      if (r_cap) r_hold <= bus.rd_data;
      if ((r_state == IDLE) && bus.start) begin
        r_addr <= bus.start_addr;
        r_len  <= bus.len;
      end
      if (w_enter) begin
        r_tail <= 1'b0;
        r_left <= (w_state_nxt == FD) ? r_len : 16'd1;
        if (w_state_nxt == FD) begin
          r_rd_addr <= r_addr;
          r_iss     <= 1'b1;
        end
      end else if (w_in_frame) begin
        if (w_tail_end) begin
          r_tail <= 1'b0;
          r_cnt  <= '0;
          r_ret  <= next_frame(r_state, r_len != 16'd0);
        end else if (r_tail) begin
          r_cnt <= r_cnt + CNT_W'(1);
        end else if (r_load_pend) begin
          if (r_left == 16'd0) begin
            r_tail <= 1'b1;
            r_cnt  <= '0;
          end else begin
            r_left <= r_left - 16'd1;
            // Fetch the following byte while this one shifts; r_hold refills two cycles later.
            if ((r_state == FD) && (r_left != 16'd1)) begin
              r_rd_addr <= r_rd_addr + ADDR_W'(1);
              r_iss     <= 1'b1;
            end
          end
        end
      end else if (r_state == GAP) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.ss      = !w_in_frame;
  assign bus.sck     = w_sck;
  assign bus.sdo     = w_sdo;
  assign bus.busy    = (r_state != IDLE) && (r_state != FIN);
  assign bus.done    = (r_state == FIN);
  assign bus.rd_addr = r_rd_addr;

endmodule
